// File: rtl/vga_timing_gen.sv
// Raster timing generator: coordinates, syncs, data-enable and line/frame strobes.
// Every output is registered and decoded from the next counter values.
module vga_timing_gen #(
  parameter int   H_RES  = 640,
  parameter int   H_FP   = 16,
  parameter int   H_SYNC = 96,
  parameter int   H_BP   = 48,
  parameter int   V_RES  = 480,
  parameter int   V_FP   = 10,
  parameter int   V_SYNC = 2,
  parameter int   V_BP   = 33,
  parameter logic H_POL  = 1'b0,
  parameter logic V_POL  = 1'b0,
  parameter int   CORDW  = 12
) (
  input  logic             clk_pix,
  input  logic             rst_pix,
  input  logic             en,
  output logic [CORDW-1:0] sx,
  output logic [CORDW-1:0] sy,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic             line,
  output logic             frame,
  output logic [15:0]      frame_cnt
);

  localparam int H_TOTAL = H_RES + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_RES + V_FP + V_SYNC + V_BP;

  localparam logic [CORDW-1:0] H_MAX    = CORDW'(H_TOTAL - 1);
  localparam logic [CORDW-1:0] V_MAX    = CORDW'(V_TOTAL - 1);
  localparam logic [CORDW-1:0] H_ACT    = CORDW'(H_RES);
  localparam logic [CORDW-1:0] V_ACT    = CORDW'(V_RES);
  localparam logic [CORDW-1:0] HS_START = CORDW'(H_RES + H_FP);
  localparam logic [CORDW-1:0] HS_END   = CORDW'(H_RES + H_FP + H_SYNC);
  localparam logic [CORDW-1:0] VS_START = CORDW'(V_RES + V_FP);
  localparam logic [CORDW-1:0] VS_END   = CORDW'(V_RES + V_FP + V_SYNC);
  localparam logic [CORDW-1:0] C_ZERO   = CORDW'(0);
  localparam logic [CORDW-1:0] C_ONE    = CORDW'(1);

  logic [CORDW-1:0] sx_d, sx_q;
  logic [CORDW-1:0] sy_d, sy_q;
  logic             hsync_d, hsync_q;
  logic             vsync_d, vsync_q;
  logic             de_d, de_q;
  logic             line_d, line_q;
  logic             frame_d, frame_q;
  logic [15:0]      frame_cnt_d, frame_cnt_q;

  // Next-state: advance the raster and decode all levels from the advanced position.
  always_comb begin
    sx_d        = sx_q;
    sy_d        = sy_q;
    hsync_d     = hsync_q;
    vsync_d     = vsync_q;
    de_d        = de_q;
    line_d      = 1'b0;
    frame_d     = 1'b0;
    frame_cnt_d = frame_cnt_q;
    if (en) begin
      if (sx_q == H_MAX) begin
        sx_d = C_ZERO;
        if (sy_q == V_MAX) begin
          sy_d = C_ZERO;
        end else begin
          sy_d = sy_q + C_ONE;
        end
      end else begin
        sx_d = sx_q + C_ONE;
        sy_d = sy_q;
      end
      hsync_d = ((sx_d >= HS_START) && (sx_d < HS_END)) ? H_POL : ~H_POL;
      vsync_d = ((sy_d >= VS_START) && (sy_d < VS_END)) ? V_POL : ~V_POL;
      de_d    = (sx_d < H_ACT) && (sy_d < V_ACT);
      line_d  = (sx_d == C_ZERO);
      frame_d = line_d && (sy_d == C_ZERO);
      if (frame_d) begin
        frame_cnt_d = frame_cnt_q + 16'd1;
      end else begin
        frame_cnt_d = frame_cnt_q;
      end
    end else begin
      line_d  = 1'b0;
      frame_d = 1'b0;
    end
  end

  // State and output registers; reset parks the raster on the last pixel of a frame.
  always_ff @(posedge clk_pix or posedge rst_pix) begin
    if (rst_pix) begin
      sx_q        <= H_MAX;
      sy_q        <= V_MAX;
      hsync_q     <= ~H_POL;
      vsync_q     <= ~V_POL;
      de_q        <= 1'b0;
      line_q      <= 1'b0;
      frame_q     <= 1'b0;
      frame_cnt_q <= 16'd0;
    end else begin
      sx_q        <= sx_d;
      sy_q        <= sy_d;
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
      de_q        <= de_d;
      line_q      <= line_d;
      frame_q     <= frame_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign sx        = sx_q;
  assign sy        = sy_q;
  assign hsync     = hsync_q;
  assign vsync     = vsync_q;
  assign de        = de_q;
  assign line      = line_q;
  assign frame     = frame_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default 640x480 instance plus a tiny active-high-sync instance,
// both compared every cycle against a raster-position reference model.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // instance 0: default geometry
  logic        rst0, en0;
  logic [11:0] sx0, sy0;
  logic        hs0_o, vs0_o, de0, line0, frame0;
  logic [15:0] fc0;

  // instance 1: 18x12 total, active-high syncs
  logic        rst1, en1;
  logic [4:0]  sx1, sy1;
  logic        hs1_o, vs1_o, de1, line1, frame1;
  logic [15:0] fc1;

  vga_timing_gen u_def (
    .clk_pix(clk), .rst_pix(rst0), .en(en0),
    .sx(sx0), .sy(sy0), .hsync(hs0_o), .vsync(vs0_o), .de(de0),
    .line(line0), .frame(frame0), .frame_cnt(fc0)
  );

  vga_timing_gen #(
    .H_RES(10), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_RES(6),  .V_FP(2), .V_SYNC(2), .V_BP(2),
    .H_POL(1'b1), .V_POL(1'b1), .CORDW(5)
  ) u_sml (
    .clk_pix(clk), .rst_pix(rst1), .en(en1),
    .sx(sx1), .sy(sy1), .hsync(hs1_o), .vsync(vs1_o), .de(de1),
    .line(line1), .frame(frame1), .frame_cnt(fc1)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // geometry of each instance, derived from its porch/sync widths
  int ht[2]   = '{800, 18};
  int vt[2]   = '{525, 12};
  int hres[2] = '{640, 10};
  int vres[2] = '{480, 6};
  int hsa[2]  = '{656, 12};
  int hsb[2]  = '{752, 15};
  int vsa[2]  = '{490, 8};
  int vsb[2]  = '{492, 10};
  int hpol[2] = '{0, 1};

  // reference model: current pixel position and strobes
  int mx[2], my[2], mfc[2];
  int ml[2], mf[2];
  bit rnd1 = 1'b0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset(input int i);
    mx[i] = ht[i] - 1;
    my[i] = vt[i] - 1;
    mfc[i] = 0;
    ml[i] = 0;
    mf[i] = 0;
  endtask

  task automatic model_step(input int i, input bit e);
    if (!e) begin
      ml[i] = 0;
      mf[i] = 0;
    end else begin
      mx[i] = (mx[i] + 1) % ht[i];
      if (mx[i] == 0) my[i] = (my[i] + 1) % vt[i];
      ml[i] = (mx[i] == 0) ? 1 : 0;
      mf[i] = (ml[i] == 1 && my[i] == 0) ? 1 : 0;
      if (mf[i] == 1) mfc[i] = (mfc[i] + 1) % 65536;
    end
  endtask

  task automatic cmp(input int i, input string p, input int gx, input int gy, input int ghs,
                     input int gvs, input int gde, input int gl, input int gf, input int gfc);
    int ehs, evs, ede;
    ehs = (mx[i] >= hsa[i] && mx[i] < hsb[i]) ? hpol[i] : 1 - hpol[i];
    evs = (my[i] >= vsa[i] && my[i] < vsb[i]) ? hpol[i] : 1 - hpol[i];
    ede = (mx[i] < hres[i] && my[i] < vres[i]) ? 1 : 0;
    check_eq({p, ".sx"}, gx, mx[i]);
    check_eq({p, ".sy"}, gy, my[i]);
    check_eq({p, ".hsync"}, ghs, ehs);
    check_eq({p, ".vsync"}, gvs, evs);
    check_eq({p, ".de"}, gde, ede);
    check_eq({p, ".line"}, gl, ml[i]);
    check_eq({p, ".frame"}, gf, mf[i]);
    check_eq({p, ".frame_cnt"}, gfc, mfc[i]);
  endtask

  task automatic cmp0();
    cmp(0, "def", int'(sx0), int'(sy0), int'(hs0_o), int'(vs0_o), int'(de0),
        int'(line0), int'(frame0), int'(fc0));
  endtask

  task automatic cmp1();
    cmp(1, "sml", int'(sx1), int'(sy1), int'(hs1_o), int'(vs1_o), int'(de1),
        int'(line1), int'(frame1), int'(fc1));
  endtask

  // one clock: advance models at the edge, compare on the falling edge, then pick new inputs
  task automatic tick();
    @(posedge clk);
    if (rst0) model_reset(0); else model_step(0, en0);
    if (rst1) model_reset(1); else model_step(1, en1);
    @(negedge clk);
    cmp0();
    cmp1();
    if (rnd1) en1 = ($urandom_range(0, 3) != 0);
  endtask

  initial begin
    int de_c, hs_c, hs_first, hs_last, budget, cnt, vs_c, fc_prev;
    rst0 = 1'b1; rst1 = 1'b1; en0 = 1'b1; en1 = 1'b1;
    model_reset(0);
    model_reset(1);
    #2;
    cmp0();
    cmp1();
    repeat (3) tick();
    check_eq("rst.sx", int'(sx0), 799);
    check_eq("rst.sy", int'(sy0), 524);
    check_eq("rst.hsync", int'(hs0_o), 1);
    check_eq("rst.vsync", int'(vs0_o), 1);
    check_eq("rst.sml_hsync", int'(hs1_o), 0);

    rst0 = 1'b0; rst1 = 1'b0;
    tick();
    check_eq("first.sx", int'(sx0), 0);
    check_eq("first.sy", int'(sy0), 0);
    check_eq("first.de", int'(de0), 1);
    check_eq("first.line", int'(line0), 1);
    check_eq("first.frame", int'(frame0), 1);
    check_eq("first.frame_cnt", int'(fc0), 1);

    // one full line on the default instance
    rnd1 = 1'b1;
    de_c = int'(de0); hs_c = 0; hs_first = -1; hs_last = -1;
    repeat (799) begin
      tick();
      if (de0) de_c++;
      if (!hs0_o) begin
        hs_c++;
        if (hs_first < 0) hs_first = int'(sx0);
        hs_last = int'(sx0);
      end
    end
    check_eq("line.de_count", de_c, 640);
    check_eq("line.hsync_count", hs_c, 96);
    check_eq("line.hsync_first", hs_first, 656);
    check_eq("line.hsync_last", hs_last, 751);
    tick();
    check_eq("line2.line", int'(line0), 1);
    check_eq("line2.sx", int'(sx0), 0);
    check_eq("line2.sy", int'(sy0), 1);

    // enable hold at sx=300
    budget = 1000;
    while (sx0 != 12'd300 && budget > 0) begin tick(); budget--; end
    check_eq("hold.reach_timeout", budget > 0 ? 1 : 0, 1);
    en0 = 1'b0;
    repeat (50) begin
      tick();
      check_eq("hold.sx", int'(sx0), 300);
    end
    en0 = 1'b1;
    tick();
    check_eq("resume.sx", int'(sx0), 301);

    // async reset between edges at sx=700
    budget = 1000;
    while (sx0 != 12'd700 && budget > 0) begin tick(); budget--; end
    check_eq("arst.reach_timeout", budget > 0 ? 1 : 0, 1);
    #2 rst0 = 1'b1;
    #1;
    model_reset(0);
    cmp0();
    check_eq("arst.sx", int'(sx0), 799);
    check_eq("arst.frame_cnt", int'(fc0), 0);
    tick();
    rst0 = 1'b0;
    tick();
    check_eq("arst.restart_sx", int'(sx0), 0);
    check_eq("arst.restart_frame", int'(frame0), 1);

    // random enable with occasional async reset on the small instance
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 299) == 0) begin
        #2 rst1 = 1'b1;
        #1;
        model_reset(1);
        cmp1();
        tick();
        rst1 = 1'b0;
      end
      tick();
    end

    // frame period and per-frame counts on the small instance
    rnd1 = 1'b0; en1 = 1'b1;
    budget = 400;
    while (!frame1 && budget > 0) begin tick(); budget--; end
    check_eq("frm.reach_timeout", budget > 0 ? 1 : 0, 1);
    fc_prev = int'(fc1);
    de_c = int'(de1); vs_c = int'(vs1_o); cnt = 0;
    budget = 400;
    do begin
      tick(); cnt++; budget--;
      if (!frame1) begin
        if (de1) de_c++;
        if (vs1_o) vs_c++;
      end
    end while (!frame1 && budget > 0);
    check_eq("frm.period", cnt, 216);
    check_eq("frm.de_count", de_c, 60);
    check_eq("frm.vsync_count", vs_c, 36);
    check_eq("frm.frame_cnt_inc", int'(fc1), (fc_prev + 1) % 65536);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Pixel-clock-domain display timing generator for the FPGA graphics path. It sits directly downstream of the pixel PLL and upstream of the pixel painter and the VGA pins. It produces the raster coordinates, sync pulses, data-enable and line/frame strobes that every later stage consumes. Default geometry is 640x480 @ 60 Hz (25 MHz pixel clock, 800x525 total).

## Interface
Parameters:
- H_RES, 640, active pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_RES, 480, active lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- H_POL, 0, hsync active level (0 = active-low)
- V_POL, 0, vsync active level (0 = active-low)
- CORDW, 12, coordinate width; must satisfy 2^CORDW >= max(H_TOTAL, V_TOTAL)

Ports:
- clk_pix  in  1  pixel clock; the only clock
- rst_pix  in  1  reset; asynchronous, active-high
- en  in  1  count enable (driven from PLL locked)
- sx  out  CORDW  horizontal position, 0..H_TOTAL-1
- sy  out  CORDW  vertical position, 0..V_TOTAL-1
- hsync  out  1  horizontal sync, polarity per H_POL
- vsync  out  1  vertical sync, polarity per V_POL
- de  out  1  data enable; high only in the active area
- line  out  1  one-cycle strobe when sx becomes 0
- frame  out  1  one-cycle strobe when sx and sy both become 0
- frame_cnt  out  16  frames started since reset, wraps

## Operation
- Derived values: H_TOTAL = H_RES+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_RES+V_FP+V_SYNC+V_BP (525).
- Line order is active, front porch, sync, back porch. Active area is sx < H_RES and sy < V_RES.
- hsync is active for H_RES+H_FP <= sx < H_RES+H_FP+H_SYNC (656..751).
- vsync is active for V_RES+V_FP <= sy < V_RES+V_FP+V_SYNC (490..491). vsync depends only on sy.
- Counting with en=1:
  - sx increments every cycle.
  - At sx=H_TOTAL-1, sx wraps to 0 and sy increments.
  - At sx=H_TOTAL-1 and sy=V_TOTAL-1, both wrap to 0.
- With en=0: sx, sy, hsync, vsync, de and frame_cnt hold; line and frame are 0.
- frame_cnt increments on the same edge that asserts frame and wraps 65535 -> 0.
- All outputs are registers. hsync, vsync, de, line and frame are decoded from the next counter values, so every output describes the same pixel as the sx/sy in the same cycle. No output has a combinational path from en.
- Coordinates are unsigned. Intermediate arithmetic uses CORDW bits with no overflow, given the CORDW constraint above.

## Timing
- Reset values (asynchronous, immediate):
  - sx=H_TOTAL-1 (799), sy=V_TOTAL-1 (524)
  - de=0, line=0, frame=0, frame_cnt=0
  - hsync=~H_POL, vsync=~V_POL (inactive)
- Reset mid-frame forces the reset values at once. No partial line completes.
- First clk_pix edge with en=1 after reset: sx=0, sy=0, de=1, line=1, frame=1, frame_cnt=1.
- Latency from en high to the first coordinate advance: 1 edge. en low freezes the output on the next edge.
- line is high for exactly one cycle per line (800 cycles apart when en is held high).
- frame is high for exactly one cycle per frame (420000 cycles apart).
- de is high 640 consecutive cycles per active line and 307200 cycles per frame.
- hsync is active 96 consecutive cycles per line. vsync is active for 2 full lines (1600 cycles), beginning with the cycle where sx=0, sy=490.

## Test plan
- Reset: hold rst_pix with en=1 -> sx=799, sy=524, de=0, hsync=vsync=1, frame_cnt=0. Release reset -> next edge gives sx=0, sy=0, de=1, frame=1, line=1, frame_cnt=1.
- Horizontal: run one line -> de=1 for sx 0..639 and 0 at sx=640; hsync=0 exactly for sx 656..751; line pulses again 800 cycles later with sy=1.
- Frame wrap: run 2 frames -> frame pulses 420000 cycles apart; sy runs 524 -> 0 together with sx 799 -> 0; vsync=0 exactly for sy 490..491; de count per frame = 307200; frame_cnt=2 after the second frame start.
- Enable: drop en at sx=300, sy=100 for 50 cycles -> all coordinates and levels hold, line=frame=0; resuming en gives sx=301 on the next edge.
- Async reset mid-line: assert rst_pix between edges at sx=700, sy=200 -> outputs take reset values before the next edge; after release, the sequence restarts at (0,0) with frame=1.
- Polarity and width: instance with H_POL=1, V_POL=1 and a frame_cnt preload run -> syncs are active-high; frame_cnt wraps 65535 -> 0 without glitching frame.
